// File: rtl/axis_to_i2s_mc_tx.sv
// rtl/axis_to_i2s_mc_tx.sv - multi-lane I2S transmitter fed by a tagged AXI-Stream sample input
// Per-channel FIFOs pop together once per frame; lanes share one SCLK/LRCLK pair.
module axis_to_i2s_mc_tx #(
    parameter int NUM_LANES  = 2,
    parameter int DATA_W     = 24,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 8,
    localparam int NUM_CH    = 2 * NUM_LANES
) (
    input  logic                 aud_mclk,
    input  logic                 aud_mrst,
    input  logic [31:0]          s_axis_aud_tdata,
    input  logic [2:0]           s_axis_aud_tid,
    input  logic                 s_axis_aud_tvalid,
    output logic                 s_axis_aud_tready,
    input  logic                 enable,
    input  logic [DIV_W-1:0]     sclk_div,
    input  logic [NUM_CH-1:0]    irq_en,
    input  logic [NUM_CH-1:0]    uflow_clr,
    output logic [NUM_CH-1:0]    uflow_status,
    output logic                 tid_err,
    output logic [NUM_CH-1:0]    fifo_empty,
    output logic                 irq,
    output logic                 lrclk_out,
    output logic                 sclk_out,
    output logic [NUM_LANES-1:0] sdata_out
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [DIV_W-1:0]    div_lat_q, div_lat_d;
    logic                sclk_q, sclk_d;
    logic                lrclk_q, lrclk_d;
    logic [5:0]          bit_cnt_q, bit_cnt_d;
    logic [31:0]         shift_q [NUM_LANES];
    logic [31:0]         shift_d [NUM_LANES];
    logic [DATA_W-1:0]   hold_q  [NUM_CH];
    logic [DATA_W-1:0]   hold_d  [NUM_CH];
    logic [DATA_W-1:0]   mem_q   [NUM_CH][FIFO_DEPTH];
    logic [DATA_W-1:0]   mem_d   [NUM_CH][FIFO_DEPTH];
    logic [AW:0]         wr_ptr_q [NUM_CH];
    logic [AW:0]         wr_ptr_d [NUM_CH];
    logic [AW:0]         rd_ptr_q [NUM_CH];
    logic [AW:0]         rd_ptr_d [NUM_CH];
    logic [NUM_CH-1:0]   uflow_q, uflow_d;
    logic                irq_q, irq_d;
    logic                tid_err_q, tid_err_d;

    logic [NUM_CH-1:0]   empty, full, push, uflow_set;
    logic                tid_ok, sel_full, accept, pop_evt;

    function automatic logic [31:0] to_slot(input logic [DATA_W-1:0] s);
        logic [31:0] slot;
        slot = '0;
        slot[31 -: DATA_W] = s;
        return slot;
    endfunction

    generate
        if (DATA_W < 32) begin : g_unused_hi
            logic unused_tdata_hi;
            assign unused_tdata_hi = ^s_axis_aud_tdata[31:DATA_W];
        end
    endgenerate

    // Input side: tready looks only at the current fill level, never at a same-cycle pop
    always_comb begin
        empty    = '0;
        full     = '0;
        push     = '0;
        sel_full = 1'b0;
        tid_ok   = ({1'b0, s_axis_aud_tid} < 4'(NUM_CH));
        for (int ch = 0; ch < NUM_CH; ch++) begin
            empty[ch] = (wr_ptr_q[ch] == rd_ptr_q[ch]);
            full[ch]  = (wr_ptr_q[ch][AW] != rd_ptr_q[ch][AW]) &&
                        (wr_ptr_q[ch][AW-1:0] == rd_ptr_q[ch][AW-1:0]);
            if (s_axis_aud_tid == 3'(ch)) sel_full = full[ch];
        end
        s_axis_aud_tready = !tid_ok || !sel_full;
        accept            = s_axis_aud_tvalid && s_axis_aud_tready;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            push[ch] = accept && tid_ok && (s_axis_aud_tid == 3'(ch));
        end
        tid_err_d = tid_err_q || (accept && !tid_ok);
    end

    always_comb begin
        mem_d     = mem_q;
        uflow_set = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            wr_ptr_d[ch] = wr_ptr_q[ch] + {{AW{1'b0}}, push[ch]};
            rd_ptr_d[ch] = rd_ptr_q[ch] + {{AW{1'b0}}, pop_evt && !empty[ch]};
            hold_d[ch]   = hold_q[ch];
            if (push[ch]) mem_d[ch][wr_ptr_q[ch][AW-1:0]] = s_axis_aud_tdata[DATA_W-1:0];
            if (pop_evt) begin
                uflow_set[ch] = empty[ch];
                hold_d[ch]    = empty[ch] ? '0 : mem_q[ch][rd_ptr_q[ch][AW-1:0]];
            end
        end
        uflow_d = (uflow_q & ~uflow_clr) | uflow_set;
        irq_d   = |(uflow_q & irq_en);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (enable)  state_d = ST_RUN;
            ST_RUN:  if (!enable) state_d = ST_IDLE;
            default:              state_d = ST_IDLE;
        endcase
    end

    // Bit clock, frame counter and per-lane shifters; shifting happens on SCLK falling events
    always_comb begin
        div_cnt_d = div_cnt_q;
        div_lat_d = div_lat_q;
        sclk_d    = sclk_q;
        lrclk_d   = lrclk_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        pop_evt   = 1'b0;
        if (state_q == ST_IDLE) begin
            if (enable) begin
                div_cnt_d = '0;
                div_lat_d = sclk_div;
                sclk_d    = 1'b0;
                bit_cnt_d = 6'd63;
                lrclk_d   = bit_cnt_d[5];
            end
        end else if (!enable) begin
            div_cnt_d = '0;
            sclk_d    = 1'b0;
            lrclk_d   = 1'b0;
            bit_cnt_d = 6'd63;
            for (int l = 0; l < NUM_LANES; l++) shift_d[l] = '0;
        end else if (div_cnt_q == div_lat_q) begin
            div_cnt_d = '0;
            sclk_d    = !sclk_q;
            if (sclk_q) begin
                bit_cnt_d = bit_cnt_q + 6'd1;
                lrclk_d   = bit_cnt_d[5];
                pop_evt   = (bit_cnt_d == 6'd0);
                for (int l = 0; l < NUM_LANES; l++) begin
                    if (bit_cnt_d == 6'd1)       shift_d[l] = to_slot(hold_q[2*l]);
                    else if (bit_cnt_d == 6'd33) shift_d[l] = to_slot(hold_q[2*l+1]);
                    else                         shift_d[l] = {shift_q[l][30:0], 1'b0};
                end
            end
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge aud_mclk) begin
        if (aud_mrst) begin
            state_q   <= ST_IDLE;
            div_cnt_q <= '0;
            div_lat_q <= '0;
            sclk_q    <= 1'b0;
            lrclk_q   <= 1'b0;
            bit_cnt_q <= 6'd63;
            uflow_q   <= '0;
            irq_q     <= 1'b0;
            tid_err_q <= 1'b0;
            for (int l = 0; l < NUM_LANES; l++) shift_q[l] <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                wr_ptr_q[ch] <= '0;
                rd_ptr_q[ch] <= '0;
                hold_q[ch]   <= '0;
            end
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            div_lat_q <= div_lat_d;
            sclk_q    <= sclk_d;
            lrclk_q   <= lrclk_d;
            bit_cnt_q <= bit_cnt_d;
            uflow_q   <= uflow_d;
            irq_q     <= irq_d;
            tid_err_q <= tid_err_d;
            shift_q   <= shift_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            hold_q    <= hold_d;
        end
    end

    always_ff @(posedge aud_mclk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) sdata_out[l] = shift_q[l][31];
    end

    assign sclk_out     = sclk_q;
    assign lrclk_out    = lrclk_q;
    assign uflow_status = uflow_q;
    assign irq          = irq_q;
    assign tid_err      = tid_err_q;
    assign fifo_empty   = empty;

endmodule

// File: tb/tb_axis_to_i2s_mc_tx.sv
// tb/tb_axis_to_i2s_mc_tx.sv - directed self-checking bench for axis_to_i2s_mc_tx
module tb_axis_to_i2s_mc_tx;
    localparam int NL = 2, NC = 4, DIVW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   tdata = '0;
    logic [2:0]    tid = '0;
    logic          tvalid = 1'b0;
    logic          tready;
    logic          enable = 1'b0;
    logic [DIVW-1:0] sclk_div = '0;
    logic [NC-1:0] irq_en = 4'b0100;
    logic [NC-1:0] uflow_clr = '0;
    logic [NC-1:0] uflow_status, fifo_empty;
    logic          tid_err, irq, lrclk, sclk;
    logic [NL-1:0] sdata;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0]   cap_sd0, cap_sd1, cap_lo, cap_hi, cap_lr;
    logic [NC-1:0] cap_empty_pre, cap_empty0, cap_uf0;
    logic          cap_irq_lo, cap_irq_hi;

    always #5 clk = ~clk;

    axis_to_i2s_mc_tx #(.NUM_LANES(NL), .DATA_W(24), .FIFO_DEPTH(8), .DIV_W(DIVW)) dut (
        .aud_mclk(clk), .aud_mrst(rst),
        .s_axis_aud_tdata(tdata), .s_axis_aud_tid(tid),
        .s_axis_aud_tvalid(tvalid), .s_axis_aud_tready(tready),
        .enable(enable), .sclk_div(sclk_div), .irq_en(irq_en),
        .uflow_clr(uflow_clr), .uflow_status(uflow_status), .tid_err(tid_err),
        .fifo_empty(fifo_empty), .irq(irq), .lrclk_out(lrclk), .sclk_out(sclk),
        .sdata_out(sdata)
    );

    // Expected serial stream: bit k of the result is the line value during bit_cnt k
    function automatic logic [63:0] exp_frame(input logic [23:0] l, input logic [23:0] r);
        logic [63:0] f;
        f = '0;
        for (int i = 0; i < 24; i++) begin
            f[1 + i]  = l[23 - i];
            f[33 + i] = r[23 - i];
        end
        return f;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; enable = 1'b0; tvalid = 1'b0; uflow_clr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push(input logic [2:0] t, input logic [31:0] d);
        @(negedge clk);
        tid = t; tdata = d; tvalid = 1'b1;
        @(posedge clk);
        #1 tvalid = 1'b0;
    endtask

    task automatic start_run(input int d);
        @(negedge clk);
        sclk_div = DIVW'(d);
        enable = 1'b1;
        @(posedge clk);
    endtask

    // Called right after the enabling edge; samples each bit slot and drops enable after nbits
    task automatic capture(input int d, input int nbits);
        cap_sd0 = '0; cap_sd1 = '0; cap_lo = '0; cap_hi = '0; cap_lr = '0;
        @(negedge clk);
        cap_empty_pre = fifo_empty;
        repeat (2 * (d + 1)) @(posedge clk);
        for (int k = 0; k < nbits; k++) begin
            @(negedge clk);
            cap_sd0[k] = sdata[0];
            cap_sd1[k] = sdata[1];
            cap_lo[k]  = sclk;
            cap_lr[k]  = lrclk;
            if (k == 0) begin
                cap_empty0 = fifo_empty;
                cap_uf0    = uflow_status;
                cap_irq_lo = irq;
            end
            repeat (d + 1) @(posedge clk);
            @(negedge clk);
            cap_hi[k] = sclk;
            if (k == 0) cap_irq_hi = irq;
            if (k == nbits - 1) enable = 1'b0;
            else repeat (d + 1) @(posedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (sclk !== 1'b0) begin n_bad++; $display("FAIL rst_sclk got %b want 0", sclk); end
        n_cmp++; if (lrclk !== 1'b0) begin n_bad++; $display("FAIL rst_lrclk got %b want 0", lrclk); end
        n_cmp++; if (sdata !== 2'b00) begin n_bad++; $display("FAIL rst_sdata got %b want 00", sdata); end
        n_cmp++; if (uflow_status !== 4'h0) begin n_bad++; $display("FAIL rst_uflow got %h want 0", uflow_status); end
        n_cmp++; if (tid_err !== 1'b0) begin n_bad++; $display("FAIL rst_tid_err got %b want 0", tid_err); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL rst_irq got %b want 0", irq); end
        n_cmp++; if (fifo_empty !== 4'hF) begin n_bad++; $display("FAIL rst_empty got %h want f", fifo_empty); end
        n_cmp++; if (tready !== 1'b1) begin n_bad++; $display("FAIL rst_tready got %b want 1", tready); end
    endtask

    task automatic test_single_lane();
        push(3'd0, 32'hFFAB_CDEF);
        push(3'd1, 32'h0012_3456);
        push(3'd2, 32'h0);
        push(3'd3, 32'h0);
        start_run(1);
        capture(1, 64);
        @(posedge clk);
        n_cmp++; if (cap_empty_pre !== 4'h0) begin n_bad++; $display("FAIL sl_empty_pre got %h want 0", cap_empty_pre); end
        n_cmp++; if (cap_sd0 !== exp_frame(24'hABCDEF, 24'h123456)) begin n_bad++; $display("FAIL sl_lane0 got %h want %h", cap_sd0, exp_frame(24'hABCDEF, 24'h123456)); end
        n_cmp++; if (cap_lo !== 64'h0) begin n_bad++; $display("FAIL sl_sclk_low got %h want 0", cap_lo); end
        n_cmp++; if (cap_hi !== {64{1'b1}}) begin n_bad++; $display("FAIL sl_sclk_high got %h want all ones", cap_hi); end
        n_cmp++; if (cap_lr !== 64'hFFFF_FFFF_0000_0000) begin n_bad++; $display("FAIL sl_lrclk got %h want ffffffff00000000", cap_lr); end
        n_cmp++; if (cap_empty0 !== 4'hF) begin n_bad++; $display("FAIL sl_empty_after_pop got %h want f", cap_empty0); end
        n_cmp++; if (cap_uf0 !== 4'h0) begin n_bad++; $display("FAIL sl_uflow got %h want 0", cap_uf0); end
    endtask

    task automatic test_multi_lane();
        push(3'd0, 32'h111111);
        push(3'd1, 32'h222222);
        push(3'd2, 32'h333333);
        push(3'd3, 32'h444444);
        start_run(0);
        capture(0, 64);
        @(posedge clk);
        n_cmp++; if (cap_sd0 !== exp_frame(24'h111111, 24'h222222)) begin n_bad++; $display("FAIL ml_lane0 got %h want %h", cap_sd0, exp_frame(24'h111111, 24'h222222)); end
        n_cmp++; if (cap_sd1 !== exp_frame(24'h333333, 24'h444444)) begin n_bad++; $display("FAIL ml_lane1 got %h want %h", cap_sd1, exp_frame(24'h333333, 24'h444444)); end
        n_cmp++; if (cap_empty_pre !== 4'h0) begin n_bad++; $display("FAIL ml_empty_pre got %h want 0", cap_empty_pre); end
        n_cmp++; if (cap_empty0 !== 4'hF) begin n_bad++; $display("FAIL ml_empty_after_pop got %h want f", cap_empty0); end
        n_cmp++; if (cap_hi !== {64{1'b1}} || cap_lo !== 64'h0) begin n_bad++; $display("FAIL ml_sclk_div0 got hi=%h lo=%h want all ones / 0", cap_hi, cap_lo); end
        n_cmp++; if (cap_uf0 !== 4'h0) begin n_bad++; $display("FAIL ml_uflow got %h want 0", cap_uf0); end
    endtask

    task automatic test_underflow();
        push(3'd0, 32'hC0FFEE);
        push(3'd1, 32'h0BEEF0);
        push(3'd3, 32'h5A5A5A);
        start_run(1);
        capture(1, 64);
        @(posedge clk);
        n_cmp++; if (cap_sd0 !== exp_frame(24'hC0FFEE, 24'h0BEEF0)) begin n_bad++; $display("FAIL uf_lane0 got %h want %h", cap_sd0, exp_frame(24'hC0FFEE, 24'h0BEEF0)); end
        n_cmp++; if (cap_sd1 !== exp_frame(24'h0, 24'h5A5A5A)) begin n_bad++; $display("FAIL uf_lane1 got %h want %h", cap_sd1, exp_frame(24'h0, 24'h5A5A5A)); end
        n_cmp++; if (cap_empty_pre !== 4'b0100) begin n_bad++; $display("FAIL uf_empty_pre got %h want 4", cap_empty_pre); end
        n_cmp++; if (cap_uf0 !== 4'b0100) begin n_bad++; $display("FAIL uf_status got %h want 4", cap_uf0); end
        n_cmp++; if (cap_irq_lo !== 1'b0) begin n_bad++; $display("FAIL uf_irq_same_cycle got %b want 0", cap_irq_lo); end
        n_cmp++; if (cap_irq_hi !== 1'b1) begin n_bad++; $display("FAIL uf_irq_next_cycle got %b want 1", cap_irq_hi); end
        @(negedge clk);
        uflow_clr = 4'b0100;
        @(posedge clk);
        @(negedge clk);
        uflow_clr = 4'b0000;
        n_cmp++; if (uflow_status !== 4'h0) begin n_bad++; $display("FAIL uf_clr_status got %h want 0", uflow_status); end
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL uf_clr_irq_lag got %b want 1", irq); end
        @(negedge clk);
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL uf_clr_irq got %b want 0", irq); end
        // Clear pulse lands on the pop edge of a new frame that underflows again
        push(3'd0, 32'h1);
        push(3'd1, 32'h2);
        push(3'd3, 32'h3);
        start_run(1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        uflow_clr = 4'b0100;
        @(posedge clk);
        @(negedge clk);
        uflow_clr = 4'b0000;
        enable = 1'b0;
        n_cmp++; if (uflow_status !== 4'b0100) begin n_bad++; $display("FAIL uf_set_wins got %h want 4", uflow_status); end
        @(posedge clk);
        @(negedge clk);
        uflow_clr = 4'hF;
        @(posedge clk);
        @(negedge clk);
        uflow_clr = 4'h0;
        @(negedge clk);
        n_cmp++; if (uflow_status !== 4'h0 || irq !== 1'b0) begin n_bad++; $display("FAIL uf_clear_all got status=%h irq=%b want 0/0", uflow_status, irq); end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 8; i++) push(3'd0, 32'h10 + i);
        @(negedge clk);
        tid = 3'd0; tdata = 32'h18; tvalid = 1'b1;
        n_cmp++; if (tready !== 1'b0) begin n_bad++; $display("FAIL bp_full got %b want 0", tready); end
        start_run(1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (tready !== 1'b0) begin n_bad++; $display("FAIL bp_before_pop got %b want 0", tready); end
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (tready !== 1'b1) begin n_bad++; $display("FAIL bp_after_pop got %b want 1", tready); end
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        tvalid = 1'b0;
        n_cmp++; if (tready !== 1'b0 || fifo_empty[0] !== 1'b0) begin n_bad++; $display("FAIL bp_refilled got tready=%b empty0=%b want 0/0", tready, fifo_empty[0]); end
    endtask

    task automatic test_bad_tid();
        do_reset();
        @(negedge clk);
        tid = 3'd5; tdata = 32'h777777; tvalid = 1'b1;
        n_cmp++; if (tready !== 1'b1) begin n_bad++; $display("FAIL bt_tready got %b want 1", tready); end
        @(posedge clk);
        @(negedge clk);
        tvalid = 1'b0;
        n_cmp++; if (tid_err !== 1'b1) begin n_bad++; $display("FAIL bt_tid_err got %b want 1", tid_err); end
        n_cmp++; if (fifo_empty !== 4'hF) begin n_bad++; $display("FAIL bt_empty got %h want f", fifo_empty); end
        repeat (3) @(negedge clk);
        n_cmp++; if (tid_err !== 1'b1) begin n_bad++; $display("FAIL bt_sticky got %b want 1", tid_err); end
    endtask

    task automatic test_midframe();
        logic [63:0] m;
        m = (64'd1 << 41) - 64'd1;
        do_reset();
        push(3'd0, 32'h876543);
        push(3'd1, 32'h8F0F0F);
        push(3'd2, 32'h2468AC);
        push(3'd3, 32'h8F0F0F);
        start_run(1);
        #1 sclk_div = 8'd3;
        capture(1, 41);
        @(negedge clk);
        n_cmp++; if ((cap_sd0 & m) !== (exp_frame(24'h876543, 24'h8F0F0F) & m)) begin n_bad++; $display("FAIL mf_lane0 got %h want %h", cap_sd0 & m, exp_frame(24'h876543, 24'h8F0F0F) & m); end
        n_cmp++; if ((cap_sd1 & m) !== (exp_frame(24'h2468AC, 24'h8F0F0F) & m)) begin n_bad++; $display("FAIL mf_lane1 got %h want %h", cap_sd1 & m, exp_frame(24'h2468AC, 24'h8F0F0F) & m); end
        n_cmp++; if (cap_hi !== m) begin n_bad++; $display("FAIL mf_div_latched got %h want %h", cap_hi, m); end
        n_cmp++; if (sclk !== 1'b0 || lrclk !== 1'b0 || sdata !== 2'b00) begin n_bad++; $display("FAIL mf_stop got sclk=%b lrclk=%b sdata=%b want 0/0/00", sclk, lrclk, sdata); end
        push(3'd0, 32'hFEDCBA);
        push(3'd1, 32'h000001);
        push(3'd2, 32'h800000);
        push(3'd3, 32'h7FFFFF);
        start_run(3);
        capture(3, 64);
        @(posedge clk);
        n_cmp++; if (cap_sd0 !== exp_frame(24'hFEDCBA, 24'h000001)) begin n_bad++; $display("FAIL mf_re_lane0 got %h want %h", cap_sd0, exp_frame(24'hFEDCBA, 24'h000001)); end
        n_cmp++; if (cap_sd1 !== exp_frame(24'h800000, 24'h7FFFFF)) begin n_bad++; $display("FAIL mf_re_lane1 got %h want %h", cap_sd1, exp_frame(24'h800000, 24'h7FFFFF)); end
        n_cmp++; if (cap_hi !== {64{1'b1}} || cap_lo !== 64'h0) begin n_bad++; $display("FAIL mf_re_period got hi=%h lo=%h want all ones / 0", cap_hi, cap_lo); end
        n_cmp++; if (cap_lr !== 64'hFFFF_FFFF_0000_0000) begin n_bad++; $display("FAIL mf_re_lrclk got %h want ffffffff00000000", cap_lr); end
        n_cmp++; if (cap_empty0 !== 4'hF || cap_uf0 !== 4'h0) begin n_bad++; $display("FAIL mf_re_pop got empty=%h uflow=%h want f/0", cap_empty0, cap_uf0); end
    endtask

    initial begin
        test_reset();
        test_single_lane();
        test_multi_lane();
        test_underflow();
        test_backpressure();
        test_bad_tid();
        test_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
